// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl_if
//  Description : Bundle of the FIFO handshake, status and RAM-port signals
//                shared between ram_fifo_ctrl and its environment.
//                  master : environment side (upstream writer, downstream
//                           reader, RAM read-data return path)
//                  slave  : controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_fifo_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 7
);
    // Write side
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    // Read side
    logic             rd_req;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    // Single-port RAM
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_din;
    logic [WIDTH-1:0] mem_dout;
    // Status
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             udf;

    modport master (
        output wr_valid, wr_data, rd_req, mem_dout,
        input  wr_ready, rd_valid, rd_data,
        input  mem_en, mem_we, mem_addr, mem_din,
        input  count, full, empty, ovf, udf
    );

    modport slave (
        input  wr_valid, wr_data, rd_req, mem_dout,
        output wr_ready, rd_valid, rd_data,
        output mem_en, mem_we, mem_addr, mem_din,
        output count, full, empty, ovf, udf
    );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : Circular-FIFO controller for one single-port RAM with
//                synchronous write and 1-cycle registered read.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - ram_fifo_ctrl_if.slave: wr_valid/wr_data/wr_ready,
//                       rd_req/rd_valid/rd_data, mem_en/mem_we/mem_addr/
//                       mem_din/mem_dout, count/full/empty/ovf/udf
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 7,
    parameter int DEPTH = 128   // must equal 2**AW; pointers wrap naturally
) (
    input  logic            clk,
    input  logic            rst,
    ram_fifo_ctrl_if.slave  bus
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_rd_valid;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_acc;
    logic             w_push_acc;
    logic             w_wr_ready;
    logic [WIDTH-1:0] w_rd_data;

    // Handshake decode. The RAM has one port, so a pop blocks any push in
    // the same cycle; the writer simply retries next cycle.
    always_comb begin
        w_full     = (r_count == c_depth);
        w_empty    = (r_count == '0);
        w_pop_acc  = bus.rd_req & ~w_empty;
        w_wr_ready = ~w_full & ~w_pop_acc & ~rst;
        w_push_acc = bus.wr_valid & w_wr_ready;
    end

    // RAM port. Idle cycles park the address on the write pointer.
    always_comb begin
        bus.mem_en   = (w_pop_acc | w_push_acc) & ~rst;
        bus.mem_we   = w_push_acc;
        bus.mem_addr = w_pop_acc ? r_rd_ptr : r_wr_ptr;
        bus.mem_din  = bus.wr_data;
    end

    // RAM contents are deliberately not cleared on reset: with count at zero
    // nothing stale can be read back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            // push and pop are mutually exclusive by construction
            if (w_push_acc) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop_acc) begin
                r_count <= r_count - c_cnt_one;
            end
            // Read data returns from the RAM one cycle after the access
            r_rd_valid <= w_pop_acc;
            r_ovf      <= r_ovf | (bus.wr_valid & w_full);
            r_udf      <= r_udf | (bus.rd_req & w_empty);
        end
    end

    assign w_rd_data    = bus.mem_dout;
    assign bus.rd_data  = w_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.wr_ready = w_wr_ready;
    assign bus.count    = r_count;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.ovf      = r_ovf;
    assign bus.udf      = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_fifo_ctrl
//  Description : Self-checking bench for ram_fifo_ctrl. Provides a
//                single-port RAM model, a queue-based FIFO reference model,
//                a directed vector table, directed corner sequences and a
//                randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus();

    ram_fifo_ctrl #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port RAM: synchronous write, registered read
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout      <= ram[bus.mem_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue plus running pointers
    logic [WIDTH-1:0] q[$];
    int               m_wptr, m_rptr;
    bit               m_rv, m_ovf, m_udf;
    logic [WIDTH-1:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wptr = 0; m_rptr = 0;
        m_rv = 0; m_ovf = 0; m_udf = 0;
        m_rdata = '0;
    endtask

    task automatic drive(input bit r, input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
        rst          = r;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_req   = rr;
    endtask

    // Compare every output against the model for the inputs now applied
    task automatic model_check();
        int cnt;
        bit emp, ful, pop, push, wrdy;
        cnt  = q.size();
        emp  = (cnt == 0);
        ful  = (cnt == DEPTH);
        pop  = bus.rd_req && !emp && !rst;
        wrdy = !ful && !(bus.rd_req && !emp) && !rst;
        push = bus.wr_valid && wrdy;
        chk("m_count",    bus.count,    cnt);
        chk("m_empty",    bus.empty,    emp);
        chk("m_full",     bus.full,     ful);
        chk("m_wr_ready", bus.wr_ready, wrdy);
        chk("m_mem_en",   bus.mem_en,   pop || push);
        chk("m_mem_we",   bus.mem_we,   push);
        if (!rst) chk("m_mem_addr", bus.mem_addr, pop ? m_rptr : m_wptr);
        chk("m_mem_din",  bus.mem_din,  bus.wr_data);
        chk("m_rd_valid", bus.rd_valid, m_rv);
        if (m_rv) chk("m_rd_data", bus.rd_data, m_rdata);
        chk("m_ovf",      bus.ovf,      m_ovf);
        chk("m_udf",      bus.udf,      m_udf);
    endtask

    // Advance the model by one clock edge using the inputs held across it
    task automatic model_edge();
        bit emp, ful, pop, push;
        emp  = (q.size() == 0);
        ful  = (q.size() == DEPTH);
        pop  = bus.rd_req && !emp;
        push = bus.wr_valid && !ful && !pop;
        if (rst) begin
            model_reset();
        end else begin
            m_rv = pop;
            if (pop) begin
                m_rdata = q.pop_front();
                m_rptr  = (m_rptr + 1) % DEPTH;
            end
            if (push) begin
                q.push_back(bus.wr_data);
                m_wptr = (m_wptr + 1) % DEPTH;
            end
            m_ovf = m_ovf || (bus.wr_valid && ful);
            m_udf = m_udf || (bus.rd_req && emp);
        end
    endtask

    task automatic cyc_pre(input bit r, input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
        drive(r, wv, wd, rr);
        @(negedge clk);
    endtask

    task automatic cyc_post();
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc(input bit r, input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
        cyc_pre(r, wv, wd, rr);
        cyc_post();
    endtask

    typedef struct {
        bit               rst;
        bit               wv;
        logic [WIDTH-1:0] wd;
        bit               rr;
        int               cnt;
        bit               emp;
        bit               ful;
        bit               wrdy;
        bit               en;
        bit               we;
        int               addr;
        bit               rv;
        logic [WIDTH-1:0] rd;
    } vec_t;

    vec_t vt[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst wv wd     rr cnt emp ful wrdy en we addr rv rd
        vt[0] = '{1, 1, 8'h99, 1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00};
        vt[1] = '{0, 1, 8'h11, 0, 0, 1, 0, 1, 1, 1, 0, 0, 8'h00};
        vt[2] = '{0, 1, 8'h22, 0, 1, 0, 0, 1, 1, 1, 1, 0, 8'h00};
        vt[3] = '{0, 1, 8'h33, 0, 2, 0, 0, 1, 1, 1, 2, 0, 8'h00};
        vt[4] = '{0, 0, 8'h00, 1, 3, 0, 0, 0, 1, 0, 0, 0, 8'h00};
        vt[5] = '{0, 0, 8'h00, 1, 2, 0, 0, 0, 1, 0, 1, 1, 8'h11};
        vt[6] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 2, 1, 8'h22};
        vt[7] = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 3, 1, 8'h33};
        vt[8] = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 3, 0, 8'h00};

        drive(1, 0, '0, 0);
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // Directed table: reset state, three pushes, three pops
        for (int i = 0; i < 9; i++) begin
            cyc_pre(vt[i].rst, vt[i].wv, vt[i].wd, vt[i].rr);
            chk($sformatf("v%0d_count", i),    bus.count,    vt[i].cnt);
            chk($sformatf("v%0d_empty", i),    bus.empty,    vt[i].emp);
            chk($sformatf("v%0d_full", i),     bus.full,     vt[i].ful);
            chk($sformatf("v%0d_wr_ready", i), bus.wr_ready, vt[i].wrdy);
            chk($sformatf("v%0d_mem_en", i),   bus.mem_en,   vt[i].en);
            chk($sformatf("v%0d_mem_we", i),   bus.mem_we,   vt[i].we);
            if (vt[i].en) chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vt[i].addr);
            chk($sformatf("v%0d_rd_valid", i), bus.rd_valid, vt[i].rv);
            if (vt[i].rv) chk($sformatf("v%0d_rd_data", i), bus.rd_data, vt[i].rd);
            cyc_post();
        end

        // Fill to full, then overflow attempt
        cyc(1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'(i), 0);
        cyc_pre(0, 1, 8'hEE, 0);
        chk("full_count",    bus.count,    DEPTH);
        chk("full_flag",     bus.full,     1);
        chk("full_wr_ready", bus.wr_ready, 0);
        chk("full_mem_en",   bus.mem_en,   0);
        cyc_post();
        chk("ovf_set",   bus.ovf,   1);
        chk("ovf_count", bus.count, DEPTH);

        // Pop one, push 0xAA into the freed slot at address 0, then drain
        cyc(0, 0, '0, 1);
        cyc_pre(0, 1, 8'hAA, 0);
        chk("wrap_we",    bus.mem_we,   1);
        chk("wrap_addr",  bus.mem_addr, 0);
        chk("wrap_first", bus.rd_data,  8'h00);
        cyc_post();
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, 1);
        cyc_pre(0, 0, '0, 0);
        chk("wrap_last_rv", bus.rd_valid, 1);
        chk("wrap_last",    bus.rd_data,  8'hAA);
        chk("wrap_empty",   bus.empty,    1);
        cyc_post();

        // Simultaneous pop and push at count 1: pop wins
        cyc(0, 1, 8'h01, 0);
        cyc_pre(0, 1, 8'h55, 1);
        chk("prio_wr_ready", bus.wr_ready, 0);
        chk("prio_we",       bus.mem_we,   0);
        chk("prio_en",       bus.mem_en,   1);
        cyc_post();
        cyc_pre(0, 1, 8'h55, 0);
        chk("prio_push_we", bus.mem_we,   1);
        chk("prio_rv",      bus.rd_valid, 1);
        chk("prio_rd",      bus.rd_data,  8'h01);
        cyc_post();
        chk("prio_count", bus.count, 1);

        // Underflow, then reset clears it
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 0);
        cyc_pre(0, 0, '0, 1);
        chk("udf_mem_en", bus.mem_en, 0);
        cyc_post();
        chk("udf_set", bus.udf,      1);
        chk("udf_rv",  bus.rd_valid, 0);
        cyc(1, 0, '0, 0);
        chk("udf_clear", bus.udf,   0);
        chk("rst_count", bus.count, 0);

        // Reset right after a pop discards the in-flight read
        cyc(0, 1, 8'h77, 0);
        cyc(0, 0, '0, 1);
        cyc_pre(1, 0, '0, 0);
        chk("inflight_rv", bus.rd_valid, 1);
        cyc_post();
        chk("discard_rv", bus.rd_valid, 0);

        // Randomized traffic with phases biased toward fill / drain
        for (int i = 0; i < 3000; i++) begin
            int pw, pr, ph;
            ph = i / 500;
            case (ph)
                0: begin pw = 70; pr = 30; end
                1: begin pw = 30; pr = 70; end
                2: begin pw = 95; pr = 5;  end
                3: begin pw = 50; pr = 50; end
                4: begin pw = 5;  pr = 95; end
                default: begin pw = 60; pr = 40; end
            endcase
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 99) < pw,
                8'($urandom),
                $urandom_range(0, 99) < pr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
